// File: rtl/hiscore_pkg.sv
// Shared types and per-game work-RAM window defaults for the hiscore RAM port.
package hiscore_pkg;

   typedef enum logic [1:0] {
      HSP_IDLE    = 2'd0,
      HSP_DRAIN   = 2'd1,
      HSP_GRANT   = 2'd2,
      HSP_RELEASE = 2'd3
   } hsp_state_t;

   localparam int unsigned DKONG_RAM_BASE  = 'h6000;
   localparam int unsigned DKONG_RAM_AW    = 12;
   localparam int unsigned GALAGA_RAM_BASE = 'h8000;
   localparam int unsigned GALAGA_RAM_AW   = 11;
   localparam int unsigned PACMAN_RAM_BASE = 'h4C00;
   localparam int unsigned PACMAN_RAM_AW   = 10;

endpackage

// File: rtl/hiscore_ram_port.sv
// Core-side responder that lends the work-RAM port to the hiscore engine
// after pausing the CPU and letting its bus drain.
module hiscore_ram_port
   import hiscore_pkg::*;
#(
   parameter int unsigned HS_AW     = 16,
   parameter int unsigned RAM_AW    = DKONG_RAM_AW,
   parameter int unsigned RAM_BASE  = DKONG_RAM_BASE,
   parameter int unsigned DRAIN_MAX = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hs_access,
   input  logic [HS_AW-1:0]  hs_address,
   input  logic [7:0]        hs_data_in,
   input  logic              hs_write,
   output logic [7:0]        hs_data_out,
   output logic              hs_grant,
   output logic              pause_req,
   input  logic              cpu_idle,
   input  logic [RAM_AW-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [7:0]        cpu_dout,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_din,
   input  logic [7:0]        ram_dout
);

   localparam int unsigned CW = $clog2(DRAIN_MAX + 1);
   localparam logic [HS_AW:0] BASE_X  = (HS_AW+1)'(RAM_BASE);
   localparam logic [HS_AW:0] LIMIT_X = BASE_X + (HS_AW+1)'(2**RAM_AW);

   hsp_state_t        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              wr_q;
   logic [RAM_AW-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic              rd_vld_q;
   logic              rd_hit_q;
   logic [7:0]        hs_data_q;
   logic              hit;
   logic              hs_side;
   logic [RAM_AW-1:0] hs_off;

   // Window check in one extra bit so the upper bound cannot wrap.
   assign hit    = ({1'b0, hs_address} >= BASE_X) && ({1'b0, hs_address} < LIMIT_X);
   assign hs_off = RAM_AW'(hs_address - BASE_X[HS_AW-1:0]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= HSP_IDLE;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 8'h00;
         rd_vld_q  <= 1'b0;
         rd_hit_q  <= 1'b0;
         hs_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= (state_q == HSP_GRANT) && hs_write && hit;
         wr_addr_q <= hs_off;
         wr_data_q <= hs_data_in;
         // A pending write steals ram_addr, so that cycle's read is not valid.
         rd_vld_q  <= (state_q == HSP_GRANT) && !wr_q;
         rd_hit_q  <= hit;
         if (rd_vld_q) begin
            hs_data_q <= rd_hit_q ? ram_dout : 8'h00;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         HSP_IDLE: begin
            if (hs_access) state_d = HSP_DRAIN;
         end
         HSP_DRAIN: begin
            cnt_d = cnt_q + CW'(1);
            if (!hs_access) begin
               state_d = HSP_IDLE;
            end else if (cpu_idle || (cnt_q == CW'(DRAIN_MAX))) begin
               state_d = HSP_GRANT;
            end
         end
         HSP_GRANT: begin
            if (!hs_access) state_d = HSP_RELEASE;
         end
         HSP_RELEASE: begin
            state_d = HSP_IDLE;
         end
         default: state_d = HSP_IDLE;
      endcase
   end

   always_comb begin
      hs_side   = (state_q == HSP_GRANT) || (state_q == HSP_RELEASE);
      hs_grant  = (state_q == HSP_GRANT) && !reset;
      pause_req = (state_q != HSP_IDLE) && !reset;
      if (hs_side) begin
         ram_addr = wr_q ? wr_addr_q : hs_off;
         ram_we   = wr_q;
         ram_din  = wr_data_q;
      end else begin
         ram_addr = cpu_addr;
         ram_we   = cpu_we;
         ram_din  = cpu_dout;
      end
      // Reset kills any pending hiscore write in the cycle it is asserted.
      if (reset) ram_we = 1'b0;
   end

   assign hs_data_out = hs_data_q;

endmodule

// File: tb/tb_hiscore_ram_port.sv
// Directed bench for hiscore_ram_port with a 1-cycle synchronous RAM model.
module tb_hiscore_ram_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        hs_access;
   logic [15:0] hs_address;
   logic [7:0]  hs_data_in;
   logic        hs_write;
   logic [7:0]  hs_data_out;
   logic        hs_grant;
   logic        pause_req;
   logic        cpu_idle;
   logic [11:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_dout;
   logic [11:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout = 8'h00;

   logic [7:0]  mem [4096] = '{default: 8'h00};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   hiscore_ram_port #(
      .HS_AW    (16),
      .RAM_AW   (12),
      .RAM_BASE ('h6000),
      .DRAIN_MAX(15)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .hs_access  (hs_access),
      .hs_address (hs_address),
      .hs_data_in (hs_data_in),
      .hs_write   (hs_write),
      .hs_data_out(hs_data_out),
      .hs_grant   (hs_grant),
      .pause_req  (pause_req),
      .cpu_idle   (cpu_idle),
      .cpu_addr   (cpu_addr),
      .cpu_we     (cpu_we),
      .cpu_dout   (cpu_dout),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_din    (ram_din),
      .ram_dout   (ram_dout)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic enter_grant();
      cpu_idle  = 1'b1;
      hs_access = 1'b1;
      step();
      step();
   endtask

   task automatic hs_wr(input logic [15:0] a, input logic [7:0] d);
      hs_address = a;
      hs_data_in = d;
      hs_write   = 1'b1;
      step();
      hs_write   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; hs_access = 1'b0; hs_address = 16'h0; hs_data_in = 8'h0; hs_write = 1'b0;
      cpu_idle = 1'b0; cpu_addr = 12'h0; cpu_we = 1'b0; cpu_dout = 8'h0;
      step(); step();
      checks++; if (hs_grant !== 1'b0) begin errors++; $display("FAIL reset_grant got %b exp 0", hs_grant); end
      checks++; if (pause_req !== 1'b0) begin errors++; $display("FAIL reset_pause got %b exp 0", pause_req); end
      checks++; if (hs_data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", hs_data_out); end
      reset = 1'b0;
      cpu_addr = 12'h123; cpu_we = 1'b1; cpu_dout = 8'h5C;
      #1;
      checks++; if ({ram_addr, ram_we, ram_din} !== {12'h123, 1'b1, 8'h5C}) begin
         errors++; $display("FAIL idle_mux got %h/%b/%h exp 123/1/5c", ram_addr, ram_we, ram_din);
      end
      step();
      cpu_we = 1'b0;
   endtask

   task automatic test_grant_timing();
      cpu_idle = 1'b1; hs_access = 1'b1;
      #1;
      checks++; if (pause_req !== 1'b0) begin errors++; $display("FAIL gt_c0_pause got %b exp 0", pause_req); end
      step();
      checks++; if ({pause_req, hs_grant} !== 2'b10) begin
         errors++; $display("FAIL gt_c1 got pause=%b grant=%b exp 1/0", pause_req, hs_grant);
      end
      step();
      checks++; if ({pause_req, hs_grant} !== 2'b11) begin
         errors++; $display("FAIL gt_c2 got pause=%b grant=%b exp 1/1", pause_req, hs_grant);
      end
   endtask

   task automatic test_write();
      hs_address = 16'h6010; hs_data_in = 8'hA5; hs_write = 1'b1;
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL wr_early got %b exp 0", ram_we); end
      step();
      hs_write = 1'b0;
      #1;
      checks++; if ({ram_we, ram_addr, ram_din} !== {1'b1, 12'h010, 8'hA5}) begin
         errors++; $display("FAIL wr_pulse got %b/%h/%h exp 1/010/a5", ram_we, ram_addr, ram_din);
      end
      step();
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL wr_single got %b exp 0", ram_we); end
      checks++; if (mem[16] !== 8'hA5) begin errors++; $display("FAIL wr_mem got %h exp a5", mem[16]); end
   endtask

   task automatic test_read();
      hs_wr(16'h6020, 8'h11);
      hs_wr(16'h6010, 8'h3C);
      hs_wr(16'h6FFF, 8'h77);
      hs_address = 16'h6020;
      step(); step(); step();
      checks++; if (hs_data_out !== 8'h11) begin errors++; $display("FAIL rd_prev got %h exp 11", hs_data_out); end
      hs_address = 16'h6010;
      step();
      checks++; if (hs_data_out !== 8'h11) begin errors++; $display("FAIL rd_lat1 got %h exp 11", hs_data_out); end
      step();
      checks++; if (hs_data_out !== 8'h3C) begin errors++; $display("FAIL rd_lat2 got %h exp 3c", hs_data_out); end
   endtask

   task automatic test_window();
      hs_address = 16'h6FFF;
      step(); step(); step();
      checks++; if (hs_data_out !== 8'h77) begin errors++; $display("FAIL win_top got %h exp 77", hs_data_out); end
      hs_address = 16'h7000; hs_data_in = 8'h99; hs_write = 1'b1;
      step();
      hs_write = 1'b0;
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL win_wr_drop got %b exp 0", ram_we); end
      step(); step();
      checks++; if (hs_data_out !== 8'h00) begin errors++; $display("FAIL win_7000 got %h exp 00", hs_data_out); end
      checks++; if (mem[0] !== 8'h00) begin errors++; $display("FAIL win_mem0 got %h exp 00", mem[0]); end
      hs_address = 16'h6FFF;
      step(); step(); step();
      hs_address = 16'h5FFF;
      step(); step();
      checks++; if (hs_data_out !== 8'h00) begin errors++; $display("FAIL win_5fff got %h exp 00", hs_data_out); end
   endtask

   task automatic test_release();
      hs_address = 16'h6005; hs_data_in = 8'h5A; hs_write = 1'b1; hs_access = 1'b0;
      step();
      hs_write = 1'b0;
      #1;
      checks++; if ({hs_grant, pause_req, ram_we, ram_addr, ram_din} !== {1'b0, 1'b1, 1'b1, 12'h005, 8'h5A}) begin
         errors++; $display("FAIL rel got g=%b p=%b we=%b a=%h d=%h exp 0/1/1/005/5a",
                            hs_grant, pause_req, ram_we, ram_addr, ram_din);
      end
      step();
      cpu_addr = 12'h0AB; cpu_we = 1'b0;
      #1;
      checks++; if ({pause_req, hs_grant} !== 2'b00) begin
         errors++; $display("FAIL rel_idle got pause=%b grant=%b exp 0/0", pause_req, hs_grant);
      end
      checks++; if (ram_addr !== 12'h0AB) begin errors++; $display("FAIL rel_cpu_mux got %h exp 0ab", ram_addr); end
      checks++; if (mem[5] !== 8'h5A) begin errors++; $display("FAIL rel_mem got %h exp 5a", mem[5]); end
   endtask

   task automatic test_drain_timeout();
      int n = 0;
      cpu_idle = 1'b0; hs_access = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (hs_grant === 1'b1) begin n = i; break; end
      end
      checks++; if (n != 17) begin errors++; $display("FAIL drain_timeout got cycle %0d exp 17", n); end
      hs_access = 1'b0;
      step(); step();
      checks++; if (pause_req !== 1'b0) begin errors++; $display("FAIL drain_exit got %b exp 0", pause_req); end
   endtask

   task automatic test_abort();
      logic seen = 1'b0;
      cpu_idle = 1'b0; hs_access = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         seen |= hs_grant;
      end
      checks++; if (pause_req !== 1'b1) begin errors++; $display("FAIL abort_drain got %b exp 1", pause_req); end
      hs_access = 1'b0; cpu_idle = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         seen |= hs_grant;
         if (i == 0) begin
            checks++; if (pause_req !== 1'b0) begin errors++; $display("FAIL abort_pause got %b exp 0", pause_req); end
         end
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_grant got %b exp 0", seen); end
   endtask

   task automatic test_reset_in_grant();
      enter_grant();
      hs_address = 16'h6FFF;
      step(); step(); step();
      checks++; if (hs_data_out !== 8'h77) begin errors++; $display("FAIL rg_pre got %h exp 77", hs_data_out); end
      hs_address = 16'h6030; hs_data_in = 8'h99; hs_write = 1'b1;
      step();
      reset = 1'b1;
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rg_we got %b exp 0", ram_we); end
      step();
      checks++; if ({hs_grant, pause_req, ram_we, hs_data_out} !== {3'b000, 8'h00}) begin
         errors++; $display("FAIL rg_outs got g=%b p=%b we=%b d=%h exp 0/0/0/00",
                            hs_grant, pause_req, ram_we, hs_data_out);
      end
      reset = 1'b0; hs_access = 1'b0;
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rg_idle_wr got %b exp 0", ram_we); end
      step();
      hs_write = 1'b0;
      checks++; if (mem[12'h030] !== 8'h00) begin errors++; $display("FAIL rg_discard got %h exp 00", mem[12'h030]); end
   endtask

   initial begin
      test_reset();
      test_grant_timing();
      test_write();
      test_read();
      test_window();
      test_release();
      test_drain_timeout();
      test_abort();
      test_reset_in_grant();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
